clk_div_meter: RTL and testbench

- Measurement-side counterpart to the team's clock divider.
- Takes a divided or external slow clock `clk_in`, synchronizes it into the system clock domain and measures period, high time and low time in system-clock cycles.
- Reports results with a one-cycle valid strobe, a stability flag and a timeout flag.
- Used on-chip and in benches to check divider ratio and duty cycle.

---
 rtl/clk_div_meter_if.sv | 19 +
 rtl/clk_div_meter.sv | 140 ++++++++++++++
 tb/tb_clk_div_meter.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/clk_div_meter_if.sv
// Measurement result bus of clk_div_meter: raw/averaged period, high/low times and status flags.
interface clk_div_meter_if #(
  parameter int CNT_W = 12
);
  logic [CNT_W-1:0] period_out;
  logic [CNT_W-1:0] high_out;
  logic [CNT_W-1:0] low_out;
  logic             meas_valid;
  logic             stable;
  logic             timeout;

  modport master (
    output period_out, high_out, low_out, meas_valid, stable, timeout
  );

  modport slave (
    input period_out, high_out, low_out, meas_valid, stable, timeout
  );
endinterface

// File: rtl/clk_div_meter.sv
// Measures period/high/low of async clk_in in clk cycles; CLK_DIV_METER_AVG_EN averages the last 4 periods.
// Latency: results land SYNC_STAGES+2 cycles after the clk_in rising edge that closes a period.
// Backpressure: none; meas_valid is a one-cycle strobe and results hold until the next one.
module clk_div_meter #(
  parameter int CNT_W       = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clk_in,
  clk_div_meter_if.master  res
);

  localparam logic [1:0]       IDLE    = 2'd0;
  localparam logic [1:0]       HIGH    = 2'd1;
  localparam logic [1:0]       LOW     = 2'd2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s, s_d, rise, fall;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt, hi_cap, last_raw;
  logic [CNT_W-1:0] period_q, high_q, low_q;
  logic             valid_q, stable_q, timeout_q, have_prev;

  logic             done, strobe;
  logic [CNT_W-1:0] hi_val, lo_val, period_new;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], clk_in};
      s_d    <= s;
    end
  end

  // A rise while still HIGH means the fall was lost: the whole period counts as high time.
  assign done   = rise && (state == HIGH || state == LOW);
  assign hi_val = (state == HIGH) ? cnt : hi_cap;
  assign lo_val = cnt - hi_val;

`ifdef CLK_DIV_METER_AVG_EN
  logic [CNT_W-1:0] hist0, hist1, hist2;
  logic [1:0]       hist_n;
  logic [CNT_W+1:0] sum;

  assign sum        = {2'b00, hist0} + {2'b00, hist1} + {2'b00, hist2} + {2'b00, cnt};
  assign period_new = sum[CNT_W+1:2];
  assign strobe     = done && (hist_n == 2'd3);

  // History only lives while a measurement is running; IDLE (incl. after timeout) wipes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist0  <= '0;
      hist1  <= '0;
      hist2  <= '0;
      hist_n <= 2'd0;
    end else if (!en || state == IDLE) begin
      hist0  <= '0;
      hist1  <= '0;
      hist2  <= '0;
      hist_n <= 2'd0;
    end else if (done) begin
      hist2  <= hist1;
      hist1  <= hist0;
      hist0  <= cnt;
      if (hist_n != 2'd3) hist_n <= hist_n + 2'd1;
    end
  end
`else
  assign period_new = cnt;
  assign strobe     = done;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      hi_cap    <= '0;
      last_raw  <= '0;
      period_q  <= '0;
      high_q    <= '0;
      low_q     <= '0;
      valid_q   <= 1'b0;
      stable_q  <= 1'b0;
      timeout_q <= 1'b0;
      have_prev <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (!en) begin
        state     <= IDLE;
        cnt       <= '0;
        stable_q  <= 1'b0;
        have_prev <= 1'b0;
      end else if (rise) begin
        state <= HIGH;
        cnt   <= {{(CNT_W-1){1'b0}}, 1'b1};
        if (strobe) begin
          period_q  <= period_new;
          high_q    <= hi_val;
          low_q     <= lo_val;
          valid_q   <= 1'b1;
          timeout_q <= 1'b0;
          stable_q  <= have_prev && (cnt == last_raw);
          last_raw  <= cnt;
          have_prev <= 1'b1;
        end
      end else if (cnt == CNT_MAX) begin
        // A rise landing on CNT_MAX is still a valid maximal period, hence rise wins above.
        state     <= IDLE;
        cnt       <= '0;
        timeout_q <= 1'b1;
        stable_q  <= 1'b0;
        have_prev <= 1'b0;
      end else begin
        cnt <= cnt + 1'b1;
        if (fall && state == HIGH) begin
          hi_cap <= cnt;
          state  <= LOW;
        end
      end
    end
  end

  assign res.period_out = period_q;
  assign res.high_out   = high_q;
  assign res.low_out    = low_q;
  assign res.meas_valid = valid_q;
  assign res.stable     = stable_q;
  assign res.timeout    = timeout_q;

endmodule

// File: tb/tb_clk_div_meter.sv
// Directed bench for clk_div_meter: lock, ratio change, timeout, enable drop, async reset (or averaging).
module tb_clk_div_meter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic clk_in = 1'b0;

  int checks = 0;
  int errors = 0;

  int cycle = 0;
  int n_strobe = 0;
  int last_strobe_cycle = 0;
  int gap = 0;
  int sp = 0, sh = 0, sl = 0, sst = 0, stmo = 0;
  int mark = 0;

  clk_div_meter_if #(.CNT_W(12)) bus ();

  clk_div_meter #(.CNT_W(12), .SYNC_STAGES(2)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .clk_in (clk_in),
    .res    (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: sample just after the rising edge and log any strobe.
  task automatic cyc();
    @(posedge clk);
    #1;
    cycle++;
    if (bus.meas_valid === 1'b1) begin
      n_strobe++;
      gap = cycle - last_strobe_cycle;
      last_strobe_cycle = cycle;
      sp   = int'(bus.period_out);
      sh   = int'(bus.high_out);
      sl   = int'(bus.low_out);
      sst  = int'(bus.stable);
      stmo = int'(bus.timeout);
    end
  endtask

  task automatic run(input int h, input int l, input int n);
    for (int i = 0; i < n; i++) begin
      clk_in = 1'b1;
      repeat (h) cyc();
      clk_in = 1'b0;
      repeat (l) cyc();
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_period"}, 32'(bus.period_out), 0);
    check({tag, "_high"},   32'(bus.high_out),   0);
    check({tag, "_low"},    32'(bus.low_out),    0);
    check({tag, "_valid"},  32'(bus.meas_valid), 0);
    check({tag, "_stable"}, 32'(bus.stable),     0);
    check({tag, "_tmo"},    32'(bus.timeout),    0);
  endtask

  initial begin
    repeat (3) cyc();
    check_all_zero("reset");
    rst_n = 1'b1;
    en    = 1'b1;
    cyc();

`ifdef CLK_DIV_METER_AVG_EN
    // First rise only arms; then raw periods 8, 8, 8 are collected silently.
    run(4, 4, 3);
    run(5, 7, 1);
    check("avg_no_strobe_3", 32'(n_strobe), 0);
    // Rise closing the 12-cycle period: mean (8+8+8+12)/4 = 9.
    run(5, 7, 1);
    check("avg_first_strobe", 32'(n_strobe), 1);
    check("avg_period_9", 32'(sp), 9);
    check("avg_high_raw", 32'(sh), 5);
    check("avg_low_raw", 32'(sl), 7);
    check("avg_stable_first", 32'(sst), 0);
    // Next: (8+8+12+12)/4 = 10, raw 12 == previous raw 12.
    run(4, 4, 1);
    check("avg_second_strobe", 32'(n_strobe), 2);
    check("avg_period_10", 32'(sp), 10);
    check("avg_stable_raw", 32'(sst), 1);
`else
    // Lock onto 4 high / 5 low.
    run(4, 5, 1);
    check("no_strobe_first_rise", 32'(n_strobe), 0);
    run(4, 5, 1);
    check("first_strobe", 32'(n_strobe), 1);
    check("first_period", 32'(sp), 9);
    check("first_high", 32'(sh), 4);
    check("first_low", 32'(sl), 5);
    check("first_stable", 32'(sst), 0);
    run(4, 5, 3);
    check("lock_strobes", 32'(n_strobe), 4);
    check("lock_stable", 32'(sst), 1);
    check("lock_gap", 32'(gap), 9);
    check("lock_period", 32'(sp), 9);

    // Ratio change to 3/3: first 6-period strobe clears stable, next sets it.
    run(3, 3, 2);
    check("chg_period", 32'(sp), 6);
    check("chg_stable_clr", 32'(sst), 0);
    run(3, 3, 1);
    check("chg2_period", 32'(sp), 6);
    check("chg2_high", 32'(sh), 3);
    check("chg2_low", 32'(sl), 3);
    check("chg2_stable", 32'(sst), 1);

    // Relock 4/5, then hold clk_in high.
    run(4, 5, 3);
    check("relock_stable", 32'(sst), 1);
    clk_in = 1'b1;
    repeat (20) cyc();
    mark = n_strobe;
    check("hold_stable_pre", 32'(bus.stable), 1);
    check("hold_period_pre", 32'(bus.period_out), 9);
    repeat (4000) cyc();
    check("hold_no_tmo_yet", 32'(bus.timeout), 0);
    repeat (980) cyc();
    check("tmo_set", 32'(bus.timeout), 1);
    check("tmo_stable_clr", 32'(bus.stable), 0);
    check("tmo_period_held", 32'(bus.period_out), 9);
    check("tmo_high_held", 32'(bus.high_out), 4);
    check("tmo_no_strobe", 32'(n_strobe), mark);

    // Resume: timeout clears on the first new strobe, which needs two rises.
    clk_in = 1'b0;
    repeat (5) cyc();
    run(4, 5, 1);
    check("resume_tmo_hold", 32'(bus.timeout), 1);
    check("resume_no_strobe", 32'(n_strobe), mark);
    run(4, 5, 1);
    check("resume_strobe", 32'(n_strobe), mark + 1);
    check("resume_tmo_clr", 32'(stmo), 0);
    check("resume_period", 32'(sp), 9);
    check("resume_stable", 32'(sst), 0);

    // Drop en in the middle of a LOW phase.
    run(4, 5, 1);
    clk_in = 1'b1;
    repeat (4) cyc();
    check("pre_en_stable", 32'(sst), 1);
    clk_in = 1'b0;
    repeat (2) cyc();
    en = 1'b0;
    mark = n_strobe;
    repeat (20) cyc();
    check("en_no_strobe", 32'(n_strobe), mark);
    check("en_stable_clr", 32'(bus.stable), 0);
    check("en_period_held", 32'(bus.period_out), 9);
    check("en_high_held", 32'(bus.high_out), 4);
    check("en_low_held", 32'(bus.low_out), 5);
    en = 1'b1;
    run(4, 5, 1);
    check("en_one_rise", 32'(n_strobe), mark);
    run(4, 5, 1);
    check("en_two_rises", 32'(n_strobe), mark + 1);
    check("en_restart_period", 32'(sp), 9);
    check("en_restart_stable", 32'(sst), 0);

    // Asynchronous reset in mid-HIGH, between clock edges.
    run(4, 5, 1);
    clk_in = 1'b1;
    repeat (6) cyc();
    #2;
    rst_n  = 1'b0;
    clk_in = 1'b0;
    #1;
    check_all_zero("arst");
    repeat (3) cyc();
    rst_n = 1'b1;
    mark = n_strobe;
    cyc();
    run(4, 5, 1);
    check("post_rst_no_strobe", 32'(n_strobe), mark);
    run(4, 5, 1);
    check("post_rst_strobe", 32'(n_strobe), mark + 1);
    check("post_rst_period", 32'(sp), 9);
    check("post_rst_high", 32'(sh), 4);
    check("post_rst_stable", 32'(sst), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
